// File: rtl/ps2_dir_if.sv
// Bundle of scan-code input, direction queue handshake and status outputs
// between the PS/2 byte source, the direction controller and the game logic.
interface ps2_dir_if;
  logic       code_valid;
  logic [7:0] code;
  logic       dir_ready;
  logic       dir_valid;
  logic [1:0] dir;
  logic       pause_pulse;
  logic       overflow;
  logic       activity_led;

  modport master (
    output code_valid, code, dir_ready,
    input  dir_valid, dir, pause_pulse, overflow, activity_led
  );

  modport slave (
    input  code_valid, code, dir_ready,
    output dir_valid, dir, pause_pulse, overflow, activity_led
  );
endinterface

// File: rtl/ps2_dir_controller.sv
// PS/2 scan-code sequencer: parses E0/F0 prefixes, suppresses typematic
// repeats, filters illegal snake turns into a 2-entry queue, pulses pause on
// Space and stretches an activity LED after every received byte.
module ps2_dir_controller #(
  parameter int unsigned HOLD_CYCLES    = 10_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [1:0]  RESET_DIR      = 2'd1
) (
  input logic       clk,
  input logic       rst,
  ps2_dir_if.slave  bus
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [HW-1:0] hold_q;
  logic [4:0]    held_q, held_d;      // bits 0..3 directions, bit 4 Space
  logic          cand_vld_q, cand_vld_d;
  logic [1:0]    cand_dir_q, cand_dir_d;
  logic          pause_q, pause_d;
  logic [1:0]    q0_q, q0_d, q1_q, q1_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [1:0]    last_dir_q, last_dir_d;

  logic          seq_done_s, seq_ext_s, seq_brk_s;
  logic          key_hit_s;
  logic [2:0]    key_id_s;
  logic [1:0]    ref_dir_s, wr_idx_s;
  logic          pop_s, legal_s, accept_s;

  // Parser next-state: prefix tracking plus idle timeout in prefix states
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    seq_done_s = 1'b0;
    seq_ext_s  = 1'b0;
    seq_brk_s  = 1'b0;
    if (bus.code_valid) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (bus.code == 8'hE0) begin
            state_d = ST_EXT;
          end else if (bus.code == 8'hF0) begin
            state_d = ST_BRK;
          end else begin
            seq_done_s = 1'b1;
          end
        end
        ST_EXT: begin
          if (bus.code == 8'hF0) begin
            state_d = ST_EXT_BRK;
          end else begin
            state_d    = ST_IDLE;
            seq_done_s = 1'b1;
            seq_ext_s  = 1'b1;
          end
        end
        ST_BRK: begin
          state_d    = ST_IDLE;
          seq_done_s = 1'b1;
          seq_brk_s  = 1'b1;
        end
        ST_EXT_BRK: begin
          state_d    = ST_IDLE;
          seq_done_s = 1'b1;
          seq_ext_s  = 1'b1;
          seq_brk_s  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = ST_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

  // Key map: arrows and WASD share direction ids 0..3, Space is id 4
  always_comb begin
    key_hit_s = 1'b1;
    key_id_s  = 3'd0;
    if (seq_ext_s) begin
      case (bus.code)
        8'h75:   key_id_s = 3'd0;
        8'h74:   key_id_s = 3'd1;
        8'h72:   key_id_s = 3'd2;
        8'h6B:   key_id_s = 3'd3;
        default: key_hit_s = 1'b0;
      endcase
    end else begin
      case (bus.code)
        8'h1D:   key_id_s = 3'd0;
        8'h23:   key_id_s = 3'd1;
        8'h1B:   key_id_s = 3'd2;
        8'h1C:   key_id_s = 3'd3;
        8'h29:   key_id_s = 3'd4;
        default: key_hit_s = 1'b0;
      endcase
    end
  end

  // Make/break handling: held mask swallows typematic repeats
  always_comb begin
    held_d     = held_q;
    cand_vld_d = 1'b0;
    cand_dir_d = cand_dir_q;
    pause_d    = 1'b0;
    if (seq_done_s && key_hit_s) begin
      if (seq_brk_s) begin
        held_d[key_id_s] = 1'b0;
      end else if (!held_q[key_id_s]) begin
        held_d[key_id_s] = 1'b1;
        if (key_id_s == 3'd4) begin
          pause_d = 1'b1;
        end else begin
          cand_vld_d = 1'b1;
          cand_dir_d = key_id_s[1:0];
        end
      end else begin
        held_d = held_q;
      end
    end else begin
      held_d = held_q;
    end
  end

  // Turn filter against the pre-pop tail, then FIFO push/pop bookkeeping
  always_comb begin
    ref_dir_s  = (cnt_q == 2'd0) ? last_dir_q : ((cnt_q == 2'd2) ? q1_q : q0_q);
    pop_s      = (cnt_q != 2'd0) && bus.dir_ready;
    legal_s    = cand_vld_q && (cand_dir_q != ref_dir_s) &&
                 (cand_dir_q != (ref_dir_s ^ 2'd2));
    accept_s   = legal_s && ((cnt_q != 2'd2) || pop_s);
    wr_idx_s   = cnt_q - {1'b0, pop_s};
    q0_d       = q0_q;
    q1_d       = q1_q;
    last_dir_d = last_dir_q;
    if (pop_s) begin
      q0_d       = q1_q;
      last_dir_d = q0_q;
    end else begin
      last_dir_d = last_dir_q;
    end
    if (accept_s) begin
      if (wr_idx_s == 2'd0) begin
        q0_d = cand_dir_q;
      end else begin
        q1_d = cand_dir_q;
      end
    end else begin
      q1_d = q1_d;
    end
    cnt_d = cnt_q + {1'b0, accept_s} - {1'b0, pop_s};
  end

  // State registers for parser, held mask, pending action and queue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tmo_q      <= '0;
      held_q     <= 5'd0;
      cand_vld_q <= 1'b0;
      cand_dir_q <= 2'd0;
      pause_q    <= 1'b0;
      q0_q       <= 2'd0;
      q1_q       <= 2'd0;
      cnt_q      <= 2'd0;
      last_dir_q <= RESET_DIR;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      held_q     <= held_d;
      cand_vld_q <= cand_vld_d;
      cand_dir_q <= cand_dir_d;
      pause_q    <= pause_d;
      q0_q       <= q0_d;
      q1_q       <= q1_d;
      cnt_q      <= cnt_d;
      last_dir_q <= last_dir_d;
    end
  end

  // Activity stretch counter: reload on every byte, saturating countdown
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else if (bus.code_valid) begin
      hold_q <= HW'(HOLD_CYCLES);
    end else if (hold_q != '0) begin
      hold_q <= hold_q - HW'(1);
    end else begin
      hold_q <= hold_q;
    end
  end

  assign bus.dir_valid    = (cnt_q != 2'd0);
  assign bus.dir          = (cnt_q != 2'd0) ? q0_q : last_dir_q;
  assign bus.pause_pulse  = pause_q;
  assign bus.overflow     = legal_s && !accept_s;
  assign bus.activity_led = (hold_q != '0);

endmodule

// File: tb/tb_ps2_dir_controller.sv
// Scoreboard bench for ps2_dir_controller: stimulus queues expected pop,
// pause and overflow events; a negedge monitor matches them as they appear.
module tb_ps2_dir_controller;
  localparam int HOLD = 16;
  localparam int TMO  = 20;

  typedef enum logic [1:0] {EV_POP, EV_PAUSE, EV_OVF} ev_e;
  typedef struct packed {
    ev_e        kind;
    logic [1:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  ev_t  exp_q[$];

  ps2_dir_if bus_if ();

  ps2_dir_controller #(
    .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO), .RESET_DIR(2'd1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_e k, input logic [1:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic match_ev(input string name, input ev_e k, input logic [1:0] v);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event kind %0d val %0d", name, k, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        n_fail++;
        $display("FAIL %s: got kind %0d val %0d expected kind %0d val %0d",
                 name, k, v, e.kind, e.val);
      end
    end
  endtask

  // Monitor: every output event is matched against the head of the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.pause_pulse) match_ev("pause_event", EV_PAUSE, 2'd0);
      if (bus_if.overflow) match_ev("overflow_event", EV_OVF, 2'd0);
      if (bus_if.dir_valid && bus_if.dir_ready) match_ev("dir_pop", EV_POP, bus_if.dir);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cyc();
    bus_if.code_valid = 1'b1;
    bus_if.code       = b;
    cyc();
    bus_if.code_valid = 1'b0;
  endtask

  // Byte whose resulting push cycle also carries a game-tick pop
  task automatic send_byte_pop(input logic [7:0] b);
    send_byte(b);
    bus_if.dir_ready = 1'b1;
    cyc();
    bus_if.dir_ready = 1'b0;
  endtask

  task automatic pop_one();
    cyc();
    bus_if.dir_ready = 1'b1;
    cyc();
    bus_if.dir_ready = 1'b0;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    bus_if.code_valid = 1'b0;
    bus_if.dir_ready  = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus_if.code_valid = 1'b0;
    bus_if.code       = 8'h00;
    bus_if.dir_ready  = 1'b0;
    do_reset();

    // Reset state
    chk("rst_dir_valid", bus_if.dir_valid, 1'b0);
    chk("rst_dir", bus_if.dir, 2'd1);
    chk("rst_pause", bus_if.pause_pulse, 1'b0);
    chk("rst_overflow", bus_if.overflow, 1'b0);
    chk("rst_led", bus_if.activity_led, 1'b0);

    // 1: extended Up from reset direction Right
    send_byte(8'hE0);
    send_byte(8'h75);
    cyc();
    chk("t1_valid", bus_if.dir_valid, 1'b1);
    chk("t1_dir", bus_if.dir, 2'd0);
    expect_ev(EV_POP, 2'd0);
    pop_one();
    chk("t1_valid_after_pop", bus_if.dir_valid, 1'b0);
    chk("t1_last_dir", bus_if.dir, 2'd0);

    // 2: A (Left) against Right is a reversal
    do_reset();
    send_byte(8'h1C);
    cyc();
    cyc();
    chk("t2_valid", bus_if.dir_valid, 1'b0);
    chk("t2_dir", bus_if.dir, 2'd1);

    // 3: typematic W, then break, then A and W again
    do_reset();
    send_byte(8'h1D);
    send_byte(8'h1D);
    send_byte(8'h1D);
    send_byte(8'hF0);
    send_byte(8'h1D);
    cyc();
    chk("t3_valid", bus_if.dir_valid, 1'b1);
    chk("t3_dir", bus_if.dir, 2'd0);
    expect_ev(EV_POP, 2'd0);
    pop_one();
    chk("t3_single_push", bus_if.dir_valid, 1'b0);
    send_byte(8'h1C);
    send_byte(8'h1D);
    cyc();
    chk("t3_rearm_dir", bus_if.dir, 2'd3);
    expect_ev(EV_POP, 2'd3);
    expect_ev(EV_POP, 2'd0);
    pop_one();
    pop_one();
    chk("t3_rearm_empty", bus_if.dir_valid, 1'b0);

    // 4a: full queue drops a legal turn with an overflow pulse
    do_reset();
    send_byte(8'hE0);
    send_byte(8'h75);
    send_byte(8'hE0);
    send_byte(8'h6B);
    cyc();
    chk("t4_full_head", bus_if.dir, 2'd0);
    expect_ev(EV_OVF, 2'd0);
    send_byte(8'h1B);
    cyc();
    cyc();
    expect_ev(EV_POP, 2'd0);
    expect_ev(EV_POP, 2'd3);
    pop_one();
    pop_one();
    chk("t4_unchanged_empty", bus_if.dir_valid, 1'b0);
    chk("t4_last_dir", bus_if.dir, 2'd3);

    // 4b: same push with a simultaneous pop is accepted
    do_reset();
    send_byte(8'hE0);
    send_byte(8'h75);
    send_byte(8'hE0);
    send_byte(8'h6B);
    cyc();
    expect_ev(EV_POP, 2'd0);
    send_byte_pop(8'h1B);
    chk("t4b_head", bus_if.dir, 2'd3);
    expect_ev(EV_POP, 2'd3);
    expect_ev(EV_POP, 2'd2);
    pop_one();
    pop_one();
    chk("t4b_empty", bus_if.dir_valid, 1'b0);
    chk("t4b_last_dir", bus_if.dir, 2'd2);

    // 5a: E0 prefix still live just inside the timeout window
    do_reset();
    send_byte(8'hE0);
    repeat (TMO - 3) cyc();
    send_byte(8'h75);
    cyc();
    chk("t5_in_time_valid", bus_if.dir_valid, 1'b1);
    chk("t5_in_time_dir", bus_if.dir, 2'd0);

    // 5b: E0 prefix expires, 75 becomes an unmapped normal make
    do_reset();
    send_byte(8'hE0);
    repeat (TMO + 5) cyc();
    send_byte(8'h75);
    cyc();
    cyc();
    chk("t5_timeout_valid", bus_if.dir_valid, 1'b0);

    // 6: Space pause pulse and activity stretch length
    do_reset();
    expect_ev(EV_PAUSE, 2'd0);
    send_byte(8'h29);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus_if.activity_led) n++;
      else break;
    end
    chk("t6_led_cycles", n, HOLD);
    chk("t6_led_off", bus_if.activity_led, 1'b0);

    // 6b: reset mid-sequence flushes queue and aborts the E0 prefix
    do_reset();
    send_byte(8'hE0);
    send_byte(8'h75);
    cyc();
    chk("t6_pre_rst_valid", bus_if.dir_valid, 1'b1);
    send_byte(8'hE0);
    do_reset();
    chk("t6_rst_flush", bus_if.dir_valid, 1'b0);
    chk("t6_rst_dir", bus_if.dir, 2'd1);
    send_byte(8'h75);
    cyc();
    cyc();
    chk("t6_rst_idle_parse", bus_if.dir_valid, 1'b0);

    repeat (3) cyc();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
